// File: rtl/seq_bin_to_bcd_ctrl_pkg.sv
// Shared types and helpers for the calculator output path.
// Holds the FSM state encoding, the BCD digit width and the digit-count sizing helper.
package calc_output_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Decimal digits needed to show the largest unsigned value of the given width.
    function automatic int min_digits(input int width);
        longint unsigned v;
        int d;
        v = (64'd1 << width) - 64'd1;
        d = 1;
        for (int i = 0; i < 20; i++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/seq_bin_to_bcd_ctrl_if.sv
// Start/ready/done handshake and data bus between the result register and the converter.
// The master side requests conversions; the slave side is the converter.
interface seq_bin_to_bcd_ctrl_if
    import calc_output_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                          start;
    logic [WIDTH-1:0]              bin;
    logic                          ready;
    logic                          busy;
    logic                          done;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd;

    modport master (
        output start, bin,
        input  ready, busy, done, bcd
    );

    modport slave (
        input  start, bin,
        output ready, busy, done, bcd
    );
endinterface

// File: rtl/seq_bin_to_bcd_ctrl_bcd_digit_correct.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more, purely combinational.
// No latency, no flow control; the caller owns any carry between digits (there is none).
module bcd_digit_correct
    import calc_output_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);
    assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;
endmodule

// File: rtl/seq_bin_to_bcd_ctrl.sv
// Sequential binary-to-BCD converter, one double-dabble iteration per clock.
// done pulses WIDTH+1 cycles after start is accepted; start is ignored unless ready (no queueing).
module seq_bin_to_bcd_ctrl
    import calc_output_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
)(
    input  logic                  clk,
    input  logic                  reset,
    seq_bin_to_bcd_ctrl_if.slave  bus
);
    localparam int SW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;
    localparam logic [1:0] S_DONE  = ST_DONE;

    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
        $error("seq_bin_to_bcd_ctrl: DIGITS too small for WIDTH");
    end

    logic [1:0]       state;
    logic [WIDTH-1:0] binreg;
    logic [SW-1:0]    scratch;
    logic [SW-1:0]    corrected;
    logic [SW-1:0]    shifted;
    logic [SW-1:0]    bcd_q;
    logic [CW-1:0]    cnt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_correct u_correct (
            .digit    (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (corrected[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Scratch half of the combined {scratch, binreg} left shift, applied after correction.
    assign shifted = {corrected[SW-2:0], binreg[WIDTH-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            binreg  <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        binreg  <= bus.bin;
                        scratch <= '0;
                        cnt     <= CNT_INIT;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    scratch <= shifted;
                    binreg  <= binreg << 1;
                    cnt     <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        bcd_q <= shifted;
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status decoded straight from the state register, so start never reaches these outputs.
    assign bus.ready = (state == S_IDLE);
    assign bus.busy  = (state == S_SHIFT) || (state == S_DONE);
    assign bus.done  = (state == S_DONE);
    assign bus.bcd   = bcd_q;

endmodule

// File: tb/tb_seq_bin_to_bcd_ctrl.sv
// Bench for seq_bin_to_bcd_ctrl at 8/3 and 10/4: vector table, corner sequences, exhaustive sweeps.
module tb_seq_bin_to_bcd_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_bin_to_bcd_ctrl_if #(.WIDTH(8),  .DIGITS(3)) b8 ();
    seq_bin_to_bcd_ctrl_if #(.WIDTH(10), .DIGITS(4)) b10 ();

    seq_bin_to_bcd_ctrl #(.WIDTH(8), .DIGITS(3)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (b8)
    );

    seq_bin_to_bcd_ctrl #(.WIDTH(10), .DIGITS(4)) dut10 (
        .clk   (clk),
        .reset (reset),
        .bus   (b10)
    );

    int checks = 0;
    int errors = 0;
    int done8_cnt = 0;
    int done10_cnt = 0;
    logic prev8 = 1'b0;
    logic prev10 = 1'b0;
    logic [11:0] q8[$];
    logic [15:0] q10[$];

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Scoreboard: every done pulse pops the oldest expected result.
    always @(negedge clk) begin
        if (b8.done === 1'b1) begin
            done8_cnt++;
            check("done8_single_cycle", {31'd0, prev8}, 0);
            if (q8.size() == 0) check("done8_unexpected", q8.size(), 1);
            else check("bcd8", {20'd0, b8.bcd}, {20'd0, q8.pop_front()});
        end
        if (b10.done === 1'b1) begin
            done10_cnt++;
            check("done10_single_cycle", {31'd0, prev10}, 0);
            if (q10.size() == 0) check("done10_unexpected", q10.size(), 1);
            else check("bcd10", {16'd0, b10.bcd}, {16'd0, q10.pop_front()});
        end
        prev8  <= b8.done;
        prev10 <= b10.done;
    end

    task automatic convert8(input logic [7:0] v, input logic [11:0] exp);
        int t;
        int n;
        t = 0;
        while (b8.ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("ready8_before_start", {31'd0, b8.ready}, 1);
        b8.start = 1'b1;
        b8.bin   = v;
        q8.push_back(exp);
        @(negedge clk);
        b8.start = 1'b0;
        b8.bin   = ~v;
        check("ready8_drop", {31'd0, b8.ready}, 0);
        check("busy8_high", {31'd0, b8.busy}, 1);
        n = 1;
        while (b8.done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("latency8", n, 9);
        @(negedge clk);
        check("ready8_after_done", {31'd0, b8.ready}, 1);
        check("busy8_after_done", {31'd0, b8.busy}, 0);
        check("bcd8_hold", {20'd0, b8.bcd}, {20'd0, exp});
    endtask

    task automatic convert10(input logic [9:0] v, input logic [15:0] exp);
        int t;
        int n;
        t = 0;
        while (b10.ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("ready10_before_start", {31'd0, b10.ready}, 1);
        b10.start = 1'b1;
        b10.bin   = v;
        q10.push_back(exp);
        @(negedge clk);
        b10.start = 1'b0;
        b10.bin   = ~v;
        n = 1;
        while (b10.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency10", n, 11);
        @(negedge clk);
        check("ready10_after_done", {31'd0, b10.ready}, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [15:0] m;
    logic [7:0]  fv;
    int          pushed;
    int          d0;
    int          t;

    initial begin
        vecs[0] = '{8'd0,   12'h000};
        vecs[1] = '{8'd255, 12'h255};
        vecs[2] = '{8'd99,  12'h099};
        vecs[3] = '{8'd128, 12'h128};
        vecs[4] = '{8'd42,  12'h042};
        vecs[5] = '{8'd200, 12'h200};
        vecs[6] = '{8'd1,   12'h001};
        vecs[7] = '{8'd9,   12'h009};
        vecs[8] = '{8'd10,  12'h010};
        vecs[9] = '{8'd100, 12'h100};

        reset     = 1'b1;
        b8.start  = 1'b0;
        b8.bin    = '0;
        b10.start = 1'b0;
        b10.bin   = '0;
        repeat (2) @(negedge clk);
        // start asserted during reset must be ignored
        b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        reset    = 1'b0;
        check("rst_ready", {31'd0, b8.ready}, 1);
        check("rst_busy",  {31'd0, b8.busy},  0);
        check("rst_done",  {31'd0, b8.done},  0);
        check("rst_bcd",   {20'd0, b8.bcd},   0);
        check("rst_bcd10", {16'd0, b10.bcd},  0);

        for (int i = 0; i < 10; i++) convert8(vecs[i].bin, vecs[i].bcd);

        // back-to-back conversions on the first ready cycle
        d0 = done8_cnt;
        convert8(8'd99, 12'h099);
        convert8(8'd128, 12'h128);
        check("b2b_done_count", done8_cnt - d0, 2);

        // start held high while bin changes every cycle: only ready cycles are accepted
        d0     = done8_cnt;
        pushed = 0;
        b8.start = 1'b1;
        for (int i = 0; i < 25; i++) begin
            fv = (i == 0) ? 8'd42 : (i == 1) ? 8'd7 : 8'(i * 37 + 5);
            b8.bin = fv;
            if (b8.ready === 1'b1) begin
                m = model(int'(fv));
                q8.push_back(m[11:0]);
                pushed++;
            end
            @(negedge clk);
        end
        b8.start = 1'b0;
        t = 0;
        while (q8.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("freerun_drain", q8.size(), 0);
        check("freerun_accepts", pushed, 3);
        check("freerun_dones", done8_cnt - d0, 3);

        // reset during the 4th SHIFT cycle aborts without done and clears bcd
        @(negedge clk);
        b8.start = 1'b1;
        b8.bin   = 8'd200;
        @(negedge clk);
        b8.start = 1'b0;
        repeat (3) @(negedge clk);
        d0    = done8_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", {31'd0, b8.ready}, 1);
        check("abort_busy",  {31'd0, b8.busy},  0);
        check("abort_bcd",   {20'd0, b8.bcd},   0);
        repeat (15) @(negedge clk);
        check("abort_no_done", done8_cnt - d0, 0);
        convert8(8'd200, 12'h200);

        for (int v = 0; v < 256; v++) begin
            m = model(v);
            convert8(8'(v), m[11:0]);
        end

        convert10(10'd1023, 16'h1023);
        for (int v = 0; v < 1024; v++) convert10(10'(v), model(v));

        repeat (3) @(negedge clk);
        check("q8_empty_end", q8.size(), 0);
        check("q10_empty_end", q10.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_bin_to_bcd_ctrl.md
Name: seq_bin_to_bcd_ctrl

Overview:
Sequential controller that converts an unsigned binary result to packed BCD using iterative shift-and-add-3 (double dabble), one bit per clock.
Replaces the unrolled combinational converter on wide calculator results, where a combinational array would be too large.
Sits between the ALU result register and the 7-segment display driver.
Uses a start/ready/done handshake so the display path latches BCD only when it is valid.

Parameters:
WIDTH, 8, bit width of the unsigned binary input.
DIGITS, 3, number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH - 1; elaboration fails otherwise.

Ports:
clk  input  1  single system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a conversion; sampled only when ready=1.
bin  input  WIDTH  unsigned binary operand; captured on the accepting edge.
ready  output  1  high when idle and able to accept start.
busy  output  1  high while a conversion is in progress (SHIFT or DONE).
done  output  1  one-cycle pulse; bcd is valid and updated in this cycle.
bcd  output  4*DIGITS  packed BCD result, ones in [3:0]; holds its value until the next done.

Behaviour:
- Reset (clk edge with reset=1): state=IDLE, ready=1, busy=0, done=0, bcd=0, internal shift/scratch/counter=0.
  - reset dominates start.
  - reset mid-conversion aborts with no done pulse and clears bcd.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - On an edge with start=1: load bin into the binary shift register, clear the BCD scratch register (4*DIGITS bits), set counter=WIDTH, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, one edge per iteration:
  - First, every scratch digit >= 5 gets +3 (4-bit, no carry between digits).
  - Then {scratch, binreg} shifts left by one; binreg LSB fills with 0.
  - Counter decrements.
  - On the edge where counter goes 1->0: transfer the post-shift scratch into bcd, go to DONE.
- DONE: done=1 for exactly this one cycle, then unconditional return to IDLE.
- Latency: start accepted at edge k; done high in the cycle following edge k+WIDTH (8 SHIFT edges at default). Throughput is one conversion per WIDTH+2 cycles.
- start while busy (SHIFT or DONE): ignored, not queued; bin changes while busy have no effect.
- ready and busy are mutually exclusive and registered from state, with no combinational path from start.
- Digit correction never sees values >9 before correction for legal parameters; no overflow handling required.
- bin=0 still runs the full WIDTH iterations. There is no early termination, so latency is fixed.

Decomposition:
- Shared package calc_output_pkg:
  - state enum (IDLE, SHIFT, DONE)
  - localparam for BCD digit width (4)
  - function computing the minimum DIGITS for a WIDTH, used in the elaboration check.
- One sub-module, bcd_digit_correct: 4-bit in, 4-bit out, out = in>=5 ? in+3 : in.
  - Instantiated DIGITS times via generate on the scratch register.
- FSM, counter and shift registers stay in the top module.

Test Plan:
- Reset then start with bin=8'd0 -> ready drops next cycle; done pulses exactly 9 cycles after the start edge; bcd=12'h000.
- start with bin=8'd255 -> done pulse; bcd=12'h255; ready returns high the cycle after done.
- Back-to-back bin=8'd99 then bin=8'd128, each start issued on the first ready cycle -> bcd=12'h099 then 12'h128; exactly two done pulses, each one cycle wide.
- start held high continuously with bin changing every cycle -> only values sampled on ready cycles are converted; starts during SHIFT/DONE are ignored (e.g. accept 8'd42, bcd=12'h042, mid-run bin=8'd7 has no effect).
- reset asserted during the 4th SHIFT cycle of bin=8'd200 -> no done pulse; bcd=0; ready=1 after the reset edge; a following conversion of 8'd200 gives 12'h200.
- Exhaustive sweep bin=0..255 with scoreboard comparing bcd against hundreds/tens/ones computed by the model -> zero mismatches, fixed latency on every conversion; repeat with WIDTH=10, DIGITS=4 (bin=1023 -> 16'h1023).
